dlsc_pcie_s6_inbound_write: RTL
===============================

// Module: dlsc_pcie_s6_inbound_write
// PURPOSE
//   Converts inbound PCIe posted Memory Write TLPs into AXI write bursts on the local bus.
//   The RX TLP dispatcher delivers a decoded header and a DWORD payload stream; this block
//   splits each TLP into AXI INCR bursts, generates byte strobes, and retires B responses.
//   Write responses are not returned to PCIe because posted writes carry no completion.
//   Error responses are reported on a status pulse.
// PARAMETERS
//   ADDR  32  AXI/TLP byte-address width
//   LEN   4   AXI awlen width; max burst = 2**LEN beats of 32 bits
//   OT    4   max outstanding AXI write bursts awaiting B (power of 2, >=2)
// PORTS
//   clk               in   1        clock
//   rst_n             in   1        reset, asynchronous, active-low
//   tlp_h_ready       out  1        header accept
//   tlp_h_valid       in   1        header valid
//   tlp_h_addr        in   ADDR-2   DWORD address [ADDR-1:2]
//   tlp_h_len         in   10       DWORD count; 0 encodes 1024
//   tlp_h_be_first    in   4        first-DW byte enables
//   tlp_h_be_last     in   4        last-DW byte enables (ignored when len==1)
//   tlp_d_ready       out  1        payload accept
//   tlp_d_valid       in   1        payload valid
//   tlp_d_data        in   32       payload DWORD
//   axi_aw_ready      in   1        AXI write-address handshake
//   axi_aw_valid      out  1        AXI write-address handshake
//   axi_aw_addr       out  ADDR     burst byte address; [1:0]=0
//   axi_aw_len        out  LEN      beats-1
//   axi_w_ready       in   1        AXI write-data handshake
//   axi_w_valid       out  1        AXI write-data handshake
//   axi_w_last        out  1        last beat of burst
//   axi_w_strb        out  4        byte strobes
//   axi_w_data        out  32       write data
//   axi_b_ready       out  1        AXI write-response handshake
//   axi_b_valid       in   1        AXI write-response handshake
//   axi_b_resp        in   2        AXI write response
//   err_valid         out  1        1-cycle pulse per B with resp!=OKAY
//   idle              out  1        no TLP in progress and no B outstanding
// BEHAVIOUR
//   Reset: all outputs 0 except idle=1. State=IDLE, counters=0.
//   FSM states:
//   - IDLE: tlp_h_ready=1. On header handshake, latch addr, remaining=(len==0)?1024:len
//     (11 bits), be_first and be_last; go to CMD.
//   - CMD: burst = min(remaining, 2**LEN - addr[LEN+1:2]), so bursts never cross a
//     2**LEN-DWORD boundary. A TLP never crosses 4 KB, so no 4 KB check is needed.
//     axi_aw_valid=1 only while outstanding<OT. On aw handshake: beat counter=burst-1,
//     outstanding+1, go to DATA. Registered aw outputs stay stable until the handshake.
//   - DATA: tlp_d_ready=axi_w_ready and axi_w_valid=tlp_d_valid (combinational pass-through).
//     - First beat of the TLP: strb=be_first.
//     - Final beat of the TLP when len>1: strb=be_last.
//     - len==1: strb=be_first only.
//     - All other beats: strb=4'hF.
//     - axi_w_last=1 when the beat counter is 0.
//     - Each beat: addr+=1 DW, remaining-=1.
//     - On the last beat of a burst: go to CMD if remaining>0, else go to IDLE.
//   - AW for the next burst is never issued before W of the current burst completes,
//     so AW/W ordering is trivially preserved.
//   Zero-length write (len=1, be_first=0): one beat with strb=0 is still issued.
//   B channel: axi_b_ready=1 always.
//   - Each B handshake decrements outstanding.
//   - AW and B handshakes in the same cycle leave outstanding unchanged.
//   - resp[1]=1 (SLVERR/DECERR) produces err_valid for 1 cycle.
//   - outstanding is never driven above OT or below 0.
//   idle = (state==IDLE) && (outstanding==0). Used by the read path to enforce PCIe
//   write-before-read ordering.
//   Payload beats presented outside DATA are not accepted (tlp_d_ready=0).
//   Asynchronous reset mid-TLP discards all state; the dispatcher must be reset together.
// STRUCTURE
//   Package dlsc_pcie_pkg holds:
//   - state encoding (IDLE/CMD/DATA)
//   - LEN_1024 decode helper
//   - AXI resp constants (OKAY=2'b00)
//   No sub-module; the outstanding counter is inline (clog2(OT)+1 bits).
// TESTING
//   1. len=1, addr=0x1000, be_first=4'b0110 -> one AW addr=0x1000 len=0; one W strb=0110
//      with last=1.
//   2. len=20, addr=0x2038 (DW 14), LEN=4 -> AW len=1 @0x2038, then AW len=15 @0x2040,
//      then AW len=1 @0x2080. Strbs: be_first, 0xF..., be_last.
//   3. len=0 (1024 DW) at a 4 KB-aligned addr -> 64 bursts of 16 beats, contiguous
//      addresses; remaining reaches 0 and FSM returns to IDLE.
//   4. Hold axi_b_valid=0 while streaming 6 x 16-DW TLPs with OT=4 -> aw_valid drops after
//      4 bursts; resumes after 1 B; idle=0 until all B are returned.
//   5. B resp=2'b10 on the 2nd burst -> err_valid pulses exactly once; the data stream is
//      unaffected.
//   6. Deassert rst_n mid-DATA with random w_ready/d_valid gaps -> all outputs return to
//      reset values asynchronously; the next TLP completes correctly.

Source files
------------

// File: rtl/dlsc_pcie_pkg.sv
// Shared definitions for the Spartan-6 PCIe inbound paths: FSM encoding,
// AXI response codes and the TLP length decode.
package dlsc_pcie_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [10:0] LEN_1024 = 11'd1024;

    // A TLP length field of zero means the maximum of 1024 DWORDs.
    function automatic logic [10:0] decode_len(input logic [9:0] len);
        return (len == 10'd0) ? LEN_1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_inbound_write.sv
// Splits inbound posted Memory Write TLPs into AXI INCR write bursts and
// retires their B responses, flagging error responses on err_valid.
module dlsc_pcie_s6_inbound_write
    import dlsc_pcie_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int OT   = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            tlp_h_ready,
    input  logic            tlp_h_valid,
    input  logic [ADDR-3:0] tlp_h_addr,
    input  logic [9:0]      tlp_h_len,
    input  logic [3:0]      tlp_h_be_first,
    input  logic [3:0]      tlp_h_be_last,

    output logic            tlp_d_ready,
    input  logic            tlp_d_valid,
    input  logic [31:0]     tlp_d_data,

    input  logic            axi_aw_ready,
    output logic            axi_aw_valid,
    output logic [ADDR-1:0] axi_aw_addr,
    output logic [LEN-1:0]  axi_aw_len,

    input  logic            axi_w_ready,
    output logic            axi_w_valid,
    output logic            axi_w_last,
    output logic [3:0]      axi_w_strb,
    output logic [31:0]     axi_w_data,

    output logic            axi_b_ready,
    input  logic            axi_b_valid,
    input  logic [1:0]      axi_b_resp,

    output logic            err_valid,
    output logic            idle
);

    localparam int OTW = $clog2(OT) + 1;

    state_t          state;
    logic            active;
    logic [ADDR-3:0] dw_addr;
    logic [10:0]     remaining;
    logic [3:0]      be_first_r;
    logic [3:0]      be_last_r;
    logic            first_beat;
    logic [LEN-1:0]  beat_cnt;
    logic [OTW-1:0]  outstanding;
    logic            aw_valid_r;
    logic [ADDR-1:0] aw_addr_r;
    logic [LEN-1:0]  aw_len_r;
    logic            err_r;

    logic [LEN:0]    space;
    logic [10:0]     burst;
    logic            aw_hs;
    logic            w_hs;
    logic            b_hs;
    logic            h_hs;
    logic            b_err;

    // Bursts stop at the next 2**LEN-DWORD boundary so they never wrap an AXI burst window.
    always_comb begin
        space = (LEN+1)'(1 << LEN) - {1'b0, dw_addr[LEN-1:0]};
        burst = (11'(space) < remaining) ? 11'(space) : remaining;
    end

    assign aw_hs = aw_valid_r && axi_aw_ready;
    assign w_hs  = (state == ST_DATA) && tlp_d_valid && axi_w_ready;
    assign b_hs  = active && axi_b_valid;
    assign h_hs  = tlp_h_ready && tlp_h_valid;
    assign b_err = (axi_b_resp == AXI_RESP_SLVERR) || (axi_b_resp == AXI_RESP_DECERR);

    assign tlp_h_ready  = active && (state == ST_IDLE);
    assign tlp_d_ready  = (state == ST_DATA) && axi_w_ready;
    assign axi_w_valid  = (state == ST_DATA) && tlp_d_valid;
    assign axi_w_last   = (state == ST_DATA) && (beat_cnt == '0);
    assign axi_w_data   = tlp_d_data;
    assign axi_b_ready  = active;
    assign axi_aw_valid = aw_valid_r;
    assign axi_aw_addr  = aw_addr_r;
    assign axi_aw_len   = aw_len_r;
    assign err_valid    = err_r;
    assign idle         = (state == ST_IDLE) && (outstanding == '0);

    // Single-DWORD TLPs take be_first only, since first and last beat coincide.
    always_comb begin
        axi_w_strb = 4'h0;
        if (state == ST_DATA) begin
            if (first_beat)
                axi_w_strb = be_first_r;
            else if (remaining == 11'd1)
                axi_w_strb = be_last_r;
            else
                axi_w_strb = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            active     <= 1'b0;
            dw_addr    <= '0;
            remaining  <= '0;
            be_first_r <= '0;
            be_last_r  <= '0;
            first_beat <= 1'b0;
            beat_cnt   <= '0;
            aw_valid_r <= 1'b0;
            aw_addr_r  <= '0;
            aw_len_r   <= '0;
            err_r      <= 1'b0;
        end else begin
            active <= 1'b1;
            err_r  <= b_hs && b_err;
            case (state)
                ST_IDLE: begin
                    if (h_hs) begin
                        dw_addr    <= tlp_h_addr;
                        remaining  <= decode_len(tlp_h_len);
                        be_first_r <= tlp_h_be_first;
                        be_last_r  <= tlp_h_be_last;
                        first_beat <= 1'b1;
                        state      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // AW is loaded once and then held untouched until accepted.
                    if (!aw_valid_r) begin
                        if (outstanding < OTW'(OT)) begin
                            aw_valid_r <= 1'b1;
                            aw_addr_r  <= {dw_addr, 2'b00};
                            aw_len_r   <= LEN'(burst - 11'd1);
                        end
                    end else if (axi_aw_ready) begin
                        aw_valid_r <= 1'b0;
                        beat_cnt   <= aw_len_r;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        dw_addr    <= dw_addr + 1'b1;
                        remaining  <= remaining - 11'd1;
                        first_beat <= 1'b0;
                        beat_cnt   <= beat_cnt - 1'b1;
                        if (beat_cnt == '0)
                            state <= (remaining == 11'd1) ? ST_IDLE : ST_CMD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({aw_hs, b_hs && (outstanding != '0)})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
